lsu_seq: RTL and testbench
==========================

Name: lsu_seq

Overview:
- Load/store sequencer between the core's memory stage and the single-ported data memory.
- Accepts one scalar load/store request at a time and issues word-aligned memory transactions with byte strobes.
- Splits misaligned accesses into two aligned transactions and merges the read halves.
- Returns load data already byte-selected and sign/zero-extended, so the memory stage takes the result as-is.

Parameters:
- ALLOW_MISALIGNED, 1: 1 = split accesses that cross a word boundary; 0 = reject them with respErr and no memory traffic.
- TIMEOUT, 255: maximum cycles to wait for memGnt or memRvalid before aborting with respErr (8-bit counter).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- reqValid  in  1  request present.
- reqReady  out  1  block can accept a request.
- reqWrite  in  1  1 = store, 0 = load.
- reqSize  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- reqUnsigned  in  1  load zero-extend (LBU/LHU); 0 = sign-extend.
- reqAddr  in  32  byte address.
- reqWdata  in  32  store data, right-justified.
- memReq  out  1  memory transaction request.
- memAddr  out  32  word-aligned address, bits [1:0] = 0.
- memWe  out  1  write enable.
- memWstrb  out  4  byte strobes.
- memWdata  out  32  lane-aligned store data.
- memGnt  in  1  transaction accepted this cycle.
- memRvalid  in  1  completion for reads and writes; memRdata is valid with it.
- memRdata  in  32  read word.
- respValid  out  1  one-cycle completion pulse.
- respErr  out  1  qualifies respValid; misaligned-reject or timeout.
- respData  out  32  extended load data; 0 for stores and errors.
- busy  out  1  state != IDLE.

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous and active-low; reset forces state IDLE and clears every output to 0 (reqReady = 0 during reset) plus all latched request fields and the timeout counter.
- Reset mid-transaction: memReq drops immediately and no response is issued.
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- IDLE:
  - reqReady = 1.
  - On reqValid: latch all request fields, offset = addr[1:0], nbytes = 1 << size, split = (offset + nbytes > 4).
  - If split && !ALLOW_MISALIGNED, go to RESP with respErr = 1.
  - Otherwise go to REQ0.
- REQ0 / REQ1:
  - memReq = 1 with stable address, memWe, memWstrb and memWdata until memGnt.
  - On memGnt, go to WAIT0 / WAIT1.
  - memReq must be 0 in every other state.
- WAIT0:
  - On memRvalid, capture memRdata into lo.
  - Then go to REQ1 if split, else RESP.
- WAIT1:
  - On memRvalid, capture memRdata into hi, then go to RESP.
- memRvalid outside WAIT0/WAIT1 is ignored.
- Lane mapping, with mask = (1 << nbytes) - 1:
  - Access 0: addr = {a[31:2], 2'b00}, strobe = (mask << offset)[3:0], data = wdata << 8*offset.
  - Access 1: addr = access-0 address + 4, wrapping modulo 2^32 (0xFFFFFFFC wraps to 0x00000000); strobe = (mask << offset)[7:4], data = wdata >> 8*(4 - offset).
- Load merge:
  - raw = ({hi, lo} >> 8*offset)[31:0]; hi = 0 when not split.
  - Byte loads: keep raw[7:0], then extend from bit 7 (sign) or with zeros (reqUnsigned).
  - Half loads: keep raw[15:0], then extend from bit 15 or with zeros.
  - Word loads: raw unchanged.
- RESP:
  - respValid = 1 for exactly one cycle with respErr and respData; then return to IDLE.
  - reqReady = 0 during RESP, so a back-to-back request is accepted no earlier than the cycle after RESP.
- Timeout:
  - Counter clears on every state entry and increments each cycle spent in REQx or WAITx.
  - When it reaches TIMEOUT, go to RESP with respErr = 1 and respData = 0.
- Latency: an aligned access with same-cycle memGnt and next-cycle memRvalid gives respValid 3 cycles after acceptance; a split access adds 2 cycles.

Test Plan:
- Aligned word load at 0x100, memRdata = 0xDEADBEEF, grant immediate, rvalid +1 -> one transaction, strobe 1111, respData = 0xDEADBEEF, respValid 3 cycles after acceptance.
- Signed LB at 0x103, memRdata = 0x80FF1234 -> strobe 1000, respData = 0xFFFFFF80; same access with reqUnsigned = 1 -> 0x00000080.
- Misaligned SW at 0x202 with wdata 0xAABBCCDD -> txn 0: addr 0x200, strobe 1100, data 0xCCDD0000; txn 1: addr 0x204, strobe 0011, data 0x0000AABB; then respValid, respErr = 0.
- Misaligned LH at 0xFFFFFFFF, reads 0x11xxxxxx then 0xxxxxxx22 -> second txn addr 0x00000000, respData = 0x00002211; with ALLOW_MISALIGNED = 0 -> respErr = 1 and memReq never asserted.
- memGnt held low -> memReq stable for TIMEOUT cycles, then respValid with respErr = 1 and state back to IDLE.
- rst_n asserted while in WAIT0 -> memReq, busy and respValid go to 0 immediately; after release, a fresh LW completes normally.

Source files
------------

// File: rtl/lsu_seq.sv
// Load/store sequencer: turns one scalar core request into one or two word-aligned
// memory transactions and returns byte-selected, extended load data.
module lsu_seq #(
    parameter bit          ALLOW_MISALIGNED = 1'b1,
    parameter int unsigned TIMEOUT          = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [1:0]  reqSize,
    input  logic        reqUnsigned,
    input  logic [31:0] reqAddr,
    input  logic [31:0] reqWdata,
    output logic        memReq,
    output logic [31:0] memAddr,
    output logic        memWe,
    output logic [3:0]  memWstrb,
    output logic [31:0] memWdata,
    input  logic        memGnt,
    input  logic        memRvalid,
    input  logic [31:0] memRdata,
    output logic        respValid,
    output logic        respErr,
    output logic [31:0] respData,
    output logic        busy
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 8;

    typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            l_write, l_uns;
    logic [1:0]      l_size;
    logic [AW-1:0]   l_addr;
    logic [DW-1:0]   l_wdata;
    logic [DW-1:0]   lo, lo_n;

    logic            accept_c;
    logic            tmo_c;
    logic            s_write;
    logic [1:0]      s_size;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_wdata;
    logic [1:0]      off_c;
    logic [2:0]      nbytes_c;
    logic [7:0]      mask_c;
    logic            split_c;
    logic [7:0]      lane_strb_c;
    logic [2*DW-1:0] lane_data_c;
    logic [AW-1:0]   addr0_c, addr1_c;
    logic [2*DW-1:0] merge_c;
    logic [DW-1:0]   raw_c, ext_c;

    logic            mem_req_n, second_n, err_n;
    logic [AW-1:0]   addr_n;
    logic [3:0]      strb_n;
    logic [DW-1:0]   wdata_n, data_n;

    assign accept_c = (state == IDLE) && reqReady && reqValid;
    assign tmo_c    = (cnt == CW'(TIMEOUT - 1));

    // Request fields come straight from the port while idle, from the latch afterwards
    assign s_write = (state == IDLE) ? reqWrite : l_write;
    assign s_size  = (state == IDLE) ? reqSize  : l_size;
    assign s_addr  = (state == IDLE) ? reqAddr  : l_addr;
    assign s_wdata = (state == IDLE) ? reqWdata : l_wdata;
    assign off_c   = s_addr[1:0];

    always_comb begin
        nbytes_c = 3'd4;
        mask_c   = 8'h0F;
        unique case (s_size)
            2'b00: begin nbytes_c = 3'd1; mask_c = 8'h01; end
            2'b01: begin nbytes_c = 3'd2; mask_c = 8'h03; end
            default: begin nbytes_c = 3'd4; mask_c = 8'h0F; end
        endcase
    end

    assign split_c     = ({2'b00, off_c} + {1'b0, nbytes_c}) > 4'd4;
    assign lane_strb_c = mask_c << off_c;
    assign lane_data_c = {32'd0, s_wdata} << {off_c, 3'b000};
    assign addr0_c     = {s_addr[AW-1:2], 2'b00};
    assign addr1_c     = addr0_c + 32'd4;

    // Load merge: low word is held in lo, high word arrives on the port in WAIT1
    assign merge_c = (state == WAIT1) ? {memRdata, lo} : {32'd0, memRdata};
    assign raw_c   = DW'(merge_c >> {off_c, 3'b000});

    always_comb begin
        ext_c = raw_c;
        unique case (s_size)
            2'b00:   ext_c = l_uns ? {24'd0, raw_c[7:0]}  : {{24{raw_c[7]}}, raw_c[7:0]};
            2'b01:   ext_c = l_uns ? {16'd0, raw_c[15:0]} : {{16{raw_c[15]}}, raw_c[15:0]};
            default: ext_c = raw_c;
        endcase
    end

    // Next state plus next values of every registered output
    always_comb begin
        state_n = state;
        lo_n    = lo;
        err_n   = 1'b0;
        data_n  = '0;
        unique case (state)
            IDLE: begin
                if (accept_c) begin
                    if (split_c && !ALLOW_MISALIGNED) begin
                        state_n = RESP;
                        err_n   = 1'b1;
                    end else begin
                        state_n = REQ0;
                    end
                end
            end
            REQ0, REQ1: begin
                if (memGnt) begin
                    state_n = (state == REQ0) ? WAIT0 : WAIT1;
                end else if (tmo_c) begin
                    state_n = RESP;
                    err_n   = 1'b1;
                end
            end
            WAIT0: begin
                if (memRvalid) begin
                    lo_n = memRdata;
                    if (split_c) begin
                        state_n = REQ1;
                    end else begin
                        state_n = RESP;
                        data_n  = s_write ? '0 : ext_c;
                    end
                end else if (tmo_c) begin
                    state_n = RESP;
                    err_n   = 1'b1;
                end
            end
            WAIT1: begin
                if (memRvalid) begin
                    state_n = RESP;
                    data_n  = s_write ? '0 : ext_c;
                end else if (tmo_c) begin
                    state_n = RESP;
                    err_n   = 1'b1;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        if (state_n != state) begin
            cnt_n = '0;
        end else if (state inside {REQ0, WAIT0, REQ1, WAIT1}) begin
            cnt_n = cnt + CW'(1);
        end else begin
            cnt_n = '0;
        end

        mem_req_n = (state_n == REQ0) || (state_n == REQ1);
        second_n  = (state_n == REQ1);
        addr_n    = '0;
        strb_n    = '0;
        wdata_n   = '0;
        if (mem_req_n) begin
            addr_n  = second_n ? addr1_c : addr0_c;
            strb_n  = second_n ? lane_strb_c[7:4] : lane_strb_c[3:0];
            if (s_write) begin
                wdata_n = second_n ? lane_data_c[63:32] : lane_data_c[31:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            l_write   <= 1'b0;
            l_uns     <= 1'b0;
            l_size    <= '0;
            l_addr    <= '0;
            l_wdata   <= '0;
            lo        <= '0;
            reqReady  <= 1'b0;
            memReq    <= 1'b0;
            memAddr   <= '0;
            memWe     <= 1'b0;
            memWstrb  <= '0;
            memWdata  <= '0;
            respValid <= 1'b0;
            respErr   <= 1'b0;
            respData  <= '0;
            busy      <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            lo    <= lo_n;
            if (accept_c) begin
                l_write <= reqWrite;
                l_uns   <= reqUnsigned;
                l_size  <= reqSize;
                l_addr  <= reqAddr;
                l_wdata <= reqWdata;
            end
            reqReady  <= (state_n == IDLE);
            memReq    <= mem_req_n;
            memAddr   <= addr_n;
            memWe     <= mem_req_n && s_write;
            memWstrb  <= strb_n;
            memWdata  <= wdata_n;
            respValid <= (state_n == RESP);
            respErr   <= err_n;
            respData  <= data_n;
            busy      <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_lsu_seq.sv
// Directed bench for lsu_seq: aligned/misaligned loads and stores, wraparound,
// misaligned reject, grant timeout and reset in the middle of a transaction.
module tb_lsu_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        reqValid, reqWrite, reqUnsigned;
    logic [1:0]  reqSize;
    logic [31:0] reqAddr, reqWdata;
    logic        reqReady, memReq, memWe, memGnt, respValid, respErr, busy;
    logic        memRvalid = 1'b0;
    logic [31:0] memRdata  = 32'd0;
    logic [31:0] memAddr, memWdata, respData;
    logic [3:0]  memWstrb;

    logic        req_valid_b;
    logic        gnt_b    = 1'b0;
    logic        rvalid_b = 1'b0;
    logic [31:0] rdata_b  = 32'd0;
    logic        ready_b, mreq_b, mwe_b, rvld_b, rerr_b, busy_b;
    logic [31:0] maddr_b, mwdata_b, rdata_out_b;
    logic [3:0]  mstrb_b;

    logic        gnt_en = 1'b1;
    logic        rv_en  = 1'b1;
    logic [4:0]  ntx    = 5'd0;
    logic [31:0] tx_addr  [0:31];
    logic        tx_we    [0:31];
    logic [3:0]  tx_strb  [0:31];
    logic [31:0] tx_wdata [0:31];
    logic [31:0] rd_tbl   [0:31];
    int          nm_req = 0;

    int vecs   = 0;
    int miscmp = 0;

    always #5 clk = ~clk;

    assign memGnt = memReq && gnt_en;

    lsu_seq dut (
        .clk(clk), .rst_n(rst_n),
        .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite), .reqSize(reqSize),
        .reqUnsigned(reqUnsigned), .reqAddr(reqAddr), .reqWdata(reqWdata),
        .memReq(memReq), .memAddr(memAddr), .memWe(memWe), .memWstrb(memWstrb),
        .memWdata(memWdata), .memGnt(memGnt), .memRvalid(memRvalid), .memRdata(memRdata),
        .respValid(respValid), .respErr(respErr), .respData(respData), .busy(busy)
    );

    lsu_seq #(.ALLOW_MISALIGNED(1'b0), .TIMEOUT(16)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .reqValid(req_valid_b), .reqReady(ready_b), .reqWrite(reqWrite), .reqSize(reqSize),
        .reqUnsigned(reqUnsigned), .reqAddr(reqAddr), .reqWdata(reqWdata),
        .memReq(mreq_b), .memAddr(maddr_b), .memWe(mwe_b), .memWstrb(mstrb_b),
        .memWdata(mwdata_b), .memGnt(gnt_b), .memRvalid(rvalid_b), .memRdata(rdata_b),
        .respValid(rvld_b), .respErr(rerr_b), .respData(rdata_out_b), .busy(busy_b)
    );

    // Memory model: log each granted transaction, answer it one cycle later
    always @(posedge clk) begin : mem_model
        logic take;
        take = memReq && memGnt;
        if (take) begin
            tx_addr[ntx]  = memAddr;
            tx_we[ntx]    = memWe;
            tx_strb[ntx]  = memWstrb;
            tx_wdata[ntx] = memWdata;
        end
        #1;
        if (take) begin
            memRvalid = rv_en;
            memRdata  = rd_tbl[ntx];
            ntx       = ntx + 5'd1;
        end else begin
            memRvalid = 1'b0;
            memRdata  = 32'd0;
        end
    end

    always @(posedge clk) if (mreq_b) nm_req++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp)
        else begin
            miscmp++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d);
        reqWrite    = w;
        reqSize     = sz;
        reqUnsigned = u;
        reqAddr     = a;
        reqWdata    = d;
        reqValid    = 1'b1;
        step();
        reqValid    = 1'b0;
    endtask

    task automatic wait_resp(output int lat);
        lat = 1;
        for (int i = 0; i < 40; i++) begin
            if (respValid) break;
            step();
            lat++;
        end
        chk("resp_seen", 32'(respValid), 32'd1);
    endtask

    task automatic after_resp();
        step();
        chk("resp_one_cycle", 32'(respValid), 32'd0);
        chk("ready_after", 32'(reqReady), 32'd1);
    endtask

    initial begin
        int          lat;
        int          hi_cnt;
        logic        stable;
        logic [4:0]  base;

        for (int i = 0; i < 32; i++) rd_tbl[i] = 32'd0;
        rst_n = 1'b0; reqValid = 1'b0; reqWrite = 1'b0; reqSize = 2'b00;
        reqUnsigned = 1'b0; reqAddr = 32'd0; reqWdata = 32'd0; req_valid_b = 1'b0;
        step(); step();
        chk("rst_ready",  32'(reqReady),  32'd0);
        chk("rst_memreq", 32'(memReq),    32'd0);
        chk("rst_resp",   32'(respValid), 32'd0);
        chk("rst_busy",   32'(busy),      32'd0);
        chk("rst_data",   respData,       32'd0);
        rst_n = 1'b1;
        step();
        chk("ready_post_rst", 32'(reqReady), 32'd1);

        // Aligned LW
        base = ntx; rd_tbl[base] = 32'hDEADBEEF;
        send(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'd0);
        chk("lw_busy", 32'(busy), 32'd1);
        chk("lw_ready_low", 32'(reqReady), 32'd0);
        wait_resp(lat);
        chk("lw_lat", 32'(lat), 32'd3);
        chk("lw_data", respData, 32'hDEADBEEF);
        chk("lw_err", 32'(respErr), 32'd0);
        chk("lw_ready_in_resp", 32'(reqReady), 32'd0);
        chk("lw_ntx", 32'(ntx - base), 32'd1);
        chk("lw_addr", tx_addr[base], 32'h0000_0100);
        chk("lw_strb", 32'(tx_strb[base]), 32'hF);
        chk("lw_we", 32'(tx_we[base]), 32'd0);
        after_resp();

        // Signed and unsigned LB at byte 3
        base = ntx; rd_tbl[base] = 32'h80FF1234;
        send(1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'd0);
        wait_resp(lat);
        chk("lb_data", respData, 32'hFFFFFF80);
        chk("lb_strb", 32'(tx_strb[base]), 32'h8);
        chk("lb_addr", tx_addr[base], 32'h0000_0100);
        after_resp();
        base = ntx; rd_tbl[base] = 32'h80FF1234;
        send(1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'd0);
        wait_resp(lat);
        chk("lbu_data", respData, 32'h00000080);
        after_resp();

        // Misaligned SW split across 0x200/0x204
        base = ntx;
        send(1'b1, 2'b10, 1'b0, 32'h0000_0202, 32'hAABBCCDD);
        wait_resp(lat);
        chk("sw_lat", 32'(lat), 32'd5);
        chk("sw_err", 32'(respErr), 32'd0);
        chk("sw_data", respData, 32'd0);
        chk("sw_ntx", 32'(ntx - base), 32'd2);
        chk("sw_addr0", tx_addr[base], 32'h0000_0200);
        chk("sw_strb0", 32'(tx_strb[base]), 32'hC);
        chk("sw_wdata0", tx_wdata[base], 32'hCCDD0000);
        chk("sw_we0", 32'(tx_we[base]), 32'd1);
        chk("sw_addr1", tx_addr[base + 5'd1], 32'h0000_0204);
        chk("sw_strb1", 32'(tx_strb[base + 5'd1]), 32'h3);
        chk("sw_wdata1", tx_wdata[base + 5'd1], 32'h0000AABB);
        after_resp();

        // Misaligned LH wrapping past 0xFFFFFFFF; reject instance sees the same request
        base = ntx; rd_tbl[base] = 32'h11AABBCC; rd_tbl[base + 5'd1] = 32'h99887722;
        req_valid_b = 1'b1;
        send(1'b0, 2'b01, 1'b0, 32'hFFFF_FFFF, 32'd0);
        req_valid_b = 1'b0;
        chk("nm_resp", 32'(rvld_b), 32'd1);
        chk("nm_err", 32'(rerr_b), 32'd1);
        chk("nm_data", rdata_out_b, 32'd0);
        wait_resp(lat);
        chk("lh_lat", 32'(lat), 32'd5);
        chk("lh_data", respData, 32'h00002211);
        chk("lh_addr0", tx_addr[base], 32'hFFFF_FFFC);
        chk("lh_addr1", tx_addr[base + 5'd1], 32'h0000_0000);
        chk("lh_strb0", 32'(tx_strb[base]), 32'h8);
        chk("lh_strb1", 32'(tx_strb[base + 5'd1]), 32'h1);
        after_resp();
        chk("nm_idle", 32'(busy_b), 32'd0);

        // Grant never arrives
        gnt_en = 1'b0;
        send(1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'd0);
        hi_cnt = 0; stable = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (respValid) break;
            if (memReq) hi_cnt++;
            if (memReq && memAddr !== 32'h0000_0300) stable = 1'b0;
            step();
        end
        chk("tmo_resp", 32'(respValid), 32'd1);
        chk("tmo_req_cycles", 32'(hi_cnt), 32'd255);
        chk("tmo_addr_stable", 32'(stable), 32'd1);
        chk("tmo_err", 32'(respErr), 32'd1);
        chk("tmo_data", respData, 32'd0);
        step();
        chk("tmo_idle", 32'(busy), 32'd0);
        chk("tmo_ready", 32'(reqReady), 32'd1);
        gnt_en = 1'b1;

        // Reset while waiting for read data
        rv_en = 1'b0;
        send(1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'd0);
        step();
        chk("w0_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("w0_rst_busy",  32'(busy),      32'd0);
        chk("w0_rst_req",   32'(memReq),    32'd0);
        chk("w0_rst_resp",  32'(respValid), 32'd0);
        chk("w0_rst_ready", 32'(reqReady),  32'd0);
        step(); step();
        chk("w0_no_resp", 32'(respValid), 32'd0);
        rst_n = 1'b1; rv_en = 1'b1;
        step();
        chk("w0_ready", 32'(reqReady), 32'd1);
        base = ntx; rd_tbl[base] = 32'h12345678;
        send(1'b0, 2'b10, 1'b0, 32'h0000_0500, 32'd0);
        wait_resp(lat);
        chk("post_rst_lat", 32'(lat), 32'd3);
        chk("post_rst_data", respData, 32'h12345678);
        chk("post_rst_err", 32'(respErr), 32'd0);
        after_resp();

        // Reset while the request is still on the bus
        gnt_en = 1'b0;
        send(1'b0, 2'b10, 1'b0, 32'h0000_0600, 32'd0);
        chk("r0_req", 32'(memReq), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("r0_rst_req", 32'(memReq), 32'd0);
        chk("r0_rst_busy", 32'(busy), 32'd0);
        step();
        rst_n = 1'b1; gnt_en = 1'b1;
        step();
        chk("r0_ready", 32'(reqReady), 32'd1);

        chk("nm_no_memreq", 32'(nm_req), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
        $finish;
    end

endmodule
